pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_entry_reg.sv | 29 ++
 rtl/pipe_stage_skid.sv | 133 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the skid-buffered pipeline stage.
//   state_e           - occupancy state of the stage (EMPTY / ONE / FULL).
//   CTRL_REGWRITE_BIT - index of the register-write enable inside the ctrl field.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int CTRL_REGWRITE_BIT = 0;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: payload register with load enable and synchronous clear.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (clears payload)
//   clr_i - synchronous clear (flush)
//   ld_i  - load d_i on the next edge
//   d_i   - payload in
//   q_o   - held payload
module pipe_entry_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) q_q <= '0;
    else if (ld_i)    q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one-cycle pipeline register with a skid entry so that
// in_ready can be registered (no combinational path from out_ready).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   flush                        - drop held entries and same-cycle input
//   in_valid/in_ready            - upstream handshake
//   in_ctrl/in_rd/in_data        - upstream payload (lane 0 in data LSBs)
//   out_valid/out_ready          - downstream handshake
//   out_ctrl/out_rd/out_data     - head entry (out_ctrl zero on a bubble)
//   occupancy                    - entries held, 0..2
//   stall_cnt/bubble_cnt         - only with PIPE_STAGE_STATS_EN defined
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 4,
  parameter int CTRL_WIDTH = 5,
  parameter int RD_WIDTH   = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic [RD_WIDTH-1:0]            in_rd,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic [RD_WIDTH-1:0]            out_rd,
  output logic [NUM_DATA*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                     occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    bubble_cnt
`endif
);

  localparam int DW = NUM_DATA * DATA_WIDTH;
  localparam int PW = CTRL_WIDTH + RD_WIDTH + DW;

  state_e          state_q, state_d;
  logic            in_ready_q;
  logic            main_ld, skid_ld;
  logic [PW-1:0]   in_pl, main_d, main_q, skid_q;
  logic            in_xfer, out_xfer;

  assign in_pl    = {in_ctrl, in_rd, in_data};
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_pl;
    case (state_q)
      EMPTY: if (in_xfer) begin
        state_d = ONE;
        main_ld = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: if (out_xfer) begin
        // in_ready is low in FULL, so the skid entry is the only candidate
        state_d = ONE;
        main_ld = 1'b1;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  // in_ready follows the next state so it is a pure flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  pipe_entry_reg #(.WIDTH(PW)) u_main (
    .clk(clk), .rst(rst), .clr_i(flush), .ld_i(main_ld), .d_i(main_d), .q_o(main_q)
  );

  pipe_entry_reg #(.WIDTH(PW)) u_skid (
    .clk(clk), .rst(rst), .clr_i(flush), .ld_i(skid_ld), .d_i(in_pl), .q_o(skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  // mask ctrl on bubbles so downstream never sees a stale register write
  assign out_ctrl  = out_valid ? main_q[PW-1 -: CTRL_WIDTH] : '0;
  assign out_rd    = main_q[DW +: RD_WIDTH];
  assign out_data  = main_q[DW-1:0];

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (!out_valid)              bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios followed by random traffic, checked
// against a queue model of the stage (FIFO of depth 2, registered ready).
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA   = 4;
  localparam int CTRL_WIDTH = 5;
  localparam int RD_WIDTH   = 5;
  localparam int DW         = NUM_DATA * DATA_WIDTH;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [RD_WIDTH-1:0]   rd;
    logic [DW-1:0]         data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_WIDTH-1:0] in_ctrl, out_ctrl;
  logic [RD_WIDTH-1:0]   in_rd, out_rd;
  logic [DW-1:0]         in_data, out_data;
  logic [1:0]            occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]           stall_cnt, bubble_cnt;
`endif

  pipe_stage_skid #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_DATA(NUM_DATA),
    .CTRL_WIDTH(CTRL_WIDTH), .RD_WIDTH(RD_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        mq[$];
  logic [31:0] m_stall = 0;
  logic [31:0] m_bubble = 0;
  ent_t        nil = '0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.ctrl = CTRL_WIDTH'($urandom);
    e.rd   = RD_WIDTH'($urandom);
    e.data = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  task automatic check_outs();
    int n = mq.size();
    chk("occupancy", 256'(occupancy), 256'(n));
    chk("in_ready", 256'(in_ready), 256'(n < 2));
    chk("out_valid", 256'(out_valid), 256'(n > 0));
    chk("out_ctrl", 256'(out_ctrl), (n > 0) ? 256'(mq[0].ctrl) : 256'(0));
    if (n > 0) begin
      chk("out_rd", 256'(out_rd), 256'(mq[0].rd));
      chk("out_data", 256'(out_data), 256'(mq[0].data));
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
    chk("bubble_cnt", 256'(bubble_cnt), 256'(m_bubble));
`endif
  endtask

  // one clock: drive inputs, advance model at the edge, check at negedge
  task automatic cyc(input bit r, input bit f, input bit v, input ent_t e, input bit ordy);
    int n;
    rst = r; flush = f; in_valid = v; out_ready = ordy;
    in_ctrl = e.ctrl; in_rd = e.rd; in_data = e.data;
    @(posedge clk);
    n = mq.size();
    if (r) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (n > 0 && !ordy) m_stall++;
      if (n == 0)         m_bubble++;
      if (f) mq.delete();
      else begin
        if (n > 0 && ordy) void'(mq.pop_front());
        if (v && n < 2)    mq.push_back(e);
      end
    end
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    ent_t e, a, b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_rd = '0; in_data = '0;
    @(negedge clk);

    // reset state
    cyc(1, 0, 0, nil, 1);
    chk("rst_out_rd", 256'(out_rd), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));

    // single transfer
    e = '0; e.data[31:0] = 32'h0000_1234; e.rd = 5'd7; e.ctrl = 5'h01;
    cyc(0, 0, 1, e, 1);
    chk("single_lane0", 256'(out_data[31:0]), 256'(32'h1234));
    chk("single_rd", 256'(out_rd), 256'(7));
    chk("single_occ", 256'(occupancy), 256'(1));
    cyc(0, 0, 0, nil, 1);

    // backpressure: A then B held, released in order
    a = rnd_ent(); b = rnd_ent();
    cyc(0, 0, 1, a, 0);
    cyc(0, 0, 1, b, 0);
    chk("bp_occ", 256'(occupancy), 256'(2));
    chk("bp_in_ready", 256'(in_ready), 256'(0));
    chk("bp_first", 256'(out_data), 256'(a.data));
    cyc(0, 0, 0, nil, 1);
    chk("bp_second", 256'(out_data), 256'(b.data));
    cyc(0, 0, 0, nil, 1);

    // full throughput
    for (int i = 1; i <= 10; i++) begin
      e = rnd_ent(); e.data = DW'(i);
      cyc(0, 0, 1, e, 1);
      chk("tput_in_ready", 256'(in_ready), 256'(1));
      chk("tput_data", 256'(out_data), 256'(i));
    end
    cyc(0, 0, 0, nil, 1);

    // flush from FULL with a same-cycle input
    cyc(0, 0, 1, rnd_ent(), 0);
    cyc(0, 0, 1, rnd_ent(), 0);
    e = rnd_ent(); e.ctrl = 5'h1f;
    cyc(0, 1, 1, e, 0);
    chk("flush_occ", 256'(occupancy), 256'(0));
    chk("flush_out_ctrl", 256'(out_ctrl), 256'(0));
    cyc(0, 0, 0, nil, 1);
    chk("flush_no_ghost", 256'(out_valid), 256'(0));

    // reset from FULL
    cyc(0, 0, 1, rnd_ent(), 0);
    cyc(0, 0, 1, rnd_ent(), 0);
    cyc(0, 0, 0, nil, 0);
    cyc(1, 1, 1, rnd_ent(), 1);
    chk("midrst_in_ready", 256'(in_ready), 256'(1));
    chk("midrst_out", 256'({out_valid, out_ctrl, out_rd, out_data}), 256'(0));
`ifdef PIPE_STAGE_STATS_EN
    chk("midrst_stall", 256'(stall_cnt), 256'(0));
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 7), rnd_ent(), ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
